irq_gateway: RTL and testbench
==============================

Name: irq_gateway

Overview:
- Peripheral-interrupt front end for the RV32IMZ SoC.
- Sits directly upstream of the core interrupt controller and drives its 16-bit peripheral_ints input, which maps to mcause bits 31:16.
- Synchronises raw asynchronous peripheral IRQ lines and applies per-source edge or level capture.
- Holds pending and in-service state per source, and provides a claim/complete handshake so that software or trap firmware acknowledges each source exactly once.

Parameters:
- NUM_SRC, 16: number of peripheral sources; must be 16 to match peripheral_ints.
- SYNC_STAGES, 2: synchroniser depth per source; legal values 2..3.
- ID_W, 4: width of source IDs; equals clog2(NUM_SRC).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high. One clock; reset is sampled only on the rising edge of clk.
- irq_src  in  NUM_SRC  raw peripheral interrupt lines, asynchronous to clk.
- cfg_edge  in  NUM_SRC  per-source mode: 1 = rising-edge triggered, 0 = level-high.
- cfg_enable  in  NUM_SRC  per-source enable mask.
- claim_req  in  1  single-cycle claim strobe.
- claim_valid  out  1  claim response strobe, asserted 1 cycle after claim_req.
- claim_none  out  1  qualifies claim_valid: no claimable source was present.
- claim_id  out  ID_W  ID of the claimed source.
- complete_valid  in  1  single-cycle completion strobe.
- complete_id  in  ID_W  ID of the source being completed.
- peripheral_ints  out  NUM_SRC  registered request lines to the interrupt controller.
- in_service  out  NUM_SRC  per-source in-service flags, for debug/CSR readback.

Behaviour:
- Reset: all synchroniser flops, the edge-history register, pending, in_service, peripheral_ints, claim_valid, claim_none and claim_id go to 0.
- Synchroniser: each irq_src[i] passes through SYNC_STAGES flops to give s[i].
  - prev[i] is a register of s[i].
  - rise[i] = s[i] & ~prev[i].
  - Latency from a pin transition to the pending update is SYNC_STAGES+1 cycles.
- Per-source states, derived from (pending, in_service):
  - IDLE: 0,0.
  - PEND: 1,0.
  - SERV: 0,1.
  - SERV_PEND: 1,1. Reachable in edge mode only.
- Set condition:
  - Edge mode: rise[i].
  - Level mode: s[i] & ~in_service[i] & ~pending[i].
- Transitions:
  - IDLE -> PEND on set.
  - PEND -> SERV on claim of i.
  - SERV -> IDLE on complete of i.
  - SERV -> SERV_PEND on rise in edge mode.
  - SERV_PEND -> PEND on complete of i.
  - A new edge in PEND or SERV_PEND is merged, not counted.
- Request output:
  - peripheral_ints[i] <= pending[i] & cfg_enable[i] & ~in_service[i], registered.
  - Latency is 1 cycle after the state update.
- Claim:
  - On claim_req, choose the highest index i with pending & cfg_enable & ~in_service, evaluated on the pre-edge state.
  - Next cycle: claim_valid=1, claim_id=i, claim_none=0.
  - If no source qualifies: claim_valid=1, claim_none=1, claim_id=0, and no state changes.
  - claim_valid is high for exactly 1 cycle.
  - A claim_req while claim_valid is high is accepted normally; back-to-back claims are legal.
- Complete:
  - Clears in_service[complete_id] only if that bit is set; otherwise it is ignored.
  - complete_id >= NUM_SRC is ignored.
- Simultaneous events in the same cycle:
  - Claim of i and an edge on i: result is SERV_PEND.
  - Claim of i and a level set on i: the claim wins, and the source is not re-pended.
  - Complete of i and claim_req: the claim selection uses the pre-edge state, so i is not claimable this cycle.
  - Complete of i with a level source still high: i re-pends on the following cycle.
- Disabling a source via cfg_enable:
  - Masks its request and claimability.
  - Pending and in_service are retained.
- Reset mid-handshake: it aborts the handshake; claim_valid is 0 in the cycle after rst.

Optional Feature:
- Macro: IRQ_GATEWAY_DROP_CNT_EN.
- With the macro defined:
  - Adds a per-source 8-bit saturating counter that increments when rise[i] occurs while pending[i] is already 1, i.e. a lost edge. It saturates at 255.
  - Adds ports cnt_sel (in, ID_W) and drop_cnt (out, 8). drop_cnt is a registered read of counter[cnt_sel] with 1-cycle latency.
  - A claim of i clears counter i.
  - Reset clears all counters.
- Without the macro: there are no counters and no extra ports.

Decomposition:
- Shared package riscv_defines.vh gains:
  - IRQ_NUM_PERIPH = 16.
  - IRQ_ID_W = 4.
  - IRQ_PERIPH_CAUSE_BASE = 16.
- Firmware computes mcause as 0x80000000 | (16+id).
- One sub-module, irq_sync_edge, holds the SYNC_STAGES synchroniser plus the prev register and rise detect for one source. It is instantiated NUM_SRC times.

Test Plan:
- Edge capture: cfg_edge=0xFFFF, enable=0xFFFF, pulse irq_src[5] high for 1 cycle -> peripheral_ints=0x0020 at cycle 4 after the pin edge; claim_req -> claim_id=5, claim_none=0; next cycle peripheral_ints=0, in_service=0x0020.
- Priority: sources 3, 9 and 14 pending -> three claims return IDs 14, 9, 3 in that order; a fourth claim returns claim_none=1, claim_id=0.
- Level re-arm: cfg_edge[2]=0, irq_src[2] held high, claim -> id 2; complete_id=2 -> pending[2]=1 on the next cycle and peripheral_ints[2]=1 on the cycle after.
- Edge during service: claim 7, then pulse irq_src[7] -> in_service[7]=1 and peripheral_ints[7]=0; complete 7 -> peripheral_ints[7]=1 again.
- Ignored complete: complete_id=10 with in_service[10]=0 -> no state change. Mask: enable[4]=0 with pending[4]=1 -> peripheral_ints[4]=0 and claim_none=1; re-enable -> request returns.
- Reset mid-claim: claim_req and rst in the same cycle -> claim_valid=0 next cycle and all outputs 0. With IRQ_GATEWAY_DROP_CNT_EN defined: 3 extra edges on source 1 while it is pending -> drop_cnt=3 at cnt_sel=1.

Source files
------------

// File: rtl/irq_gateway_pkg.sv
// Shared definitions for the peripheral interrupt gateway.
// Source IDs map to mcause = 0x80000000 | (IRQ_PERIPH_CAUSE_BASE + id).
package irq_gateway_pkg;

    localparam int IRQ_NUM_PERIPH        = 16;
    localparam int IRQ_ID_W              = 4;
    localparam int IRQ_PERIPH_CAUSE_BASE = 16;
    localparam int DROP_CNT_W            = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        SERV      = 2'b01,
        PEND      = 2'b10,
        SERV_PEND = 2'b11
    } src_state_e;

    // Bit 1 is pending, bit 0 is in-service
    function automatic src_state_e src_next(
        input src_state_e cur,
        input logic       set,
        input logic       claim,
        input logic       done
    );
        logic p;
        logic s;
        p = (cur[1] & ~claim) | set;
        s = (cur[0] & ~done) | claim;
        return src_state_e'({p, s});
    endfunction

    function automatic logic [31:0] irq_mcause(input logic [IRQ_ID_W-1:0] id);
        return 32'h8000_0000 | 32'(IRQ_PERIPH_CAUSE_BASE + int'(id));
    endfunction

endpackage

// File: rtl/irq_gateway_sync_edge.sv
// Per-source synchroniser with rising-edge detect (module irq_sync_edge).
// Level output is the last sync flop; rise compares it against a history flop.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;

endmodule

// File: rtl/irq_gateway.sv
// Peripheral IRQ gateway: sync, edge/level capture, claim/complete handshake.
// Optional lost-edge counters with IRQ_GATEWAY_DROP_CNT_EN.
module irq_gateway
    import irq_gateway_pkg::*;
#(
    parameter int NUM_SRC     = IRQ_NUM_PERIPH,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = IRQ_ID_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] cfg_edge,
    input  logic [NUM_SRC-1:0] cfg_enable,
    input  logic               claim_req,
    output logic               claim_valid,
    output logic               claim_none,
    output logic [ID_W-1:0]    claim_id,
    input  logic               complete_valid,
    input  logic [ID_W-1:0]    complete_id,
`ifdef IRQ_GATEWAY_DROP_CNT_EN
    input  logic [ID_W-1:0]    cnt_sel,
    output logic [7:0]         drop_cnt,
`endif
    output logic [NUM_SRC-1:0] peripheral_ints,
    output logic [NUM_SRC-1:0] in_service
);

    logic [NUM_SRC-1:0] lvl;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] serv;
    logic [NUM_SRC-1:0] claimable;
    logic [NUM_SRC-1:0] set_vec;
    logic [NUM_SRC-1:0] claim_vec;
    logic [NUM_SRC-1:0] done_vec;
    logic [ID_W-1:0]    sel;
    logic               found;
    src_state_e         st_q [NUM_SRC];
    src_state_e         st_d [NUM_SRC];
    logic [NUM_SRC-1:0] req_q;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk    (clk),
            .rst    (rst),
            .irq_in (irq_src[g]),
            .level  (lvl[g]),
            .rise   (rise[g])
        );
    end

    always_comb begin
        pend = '0;
        serv = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pend[i] = st_q[i][1];
            serv[i] = st_q[i][0];
        end
    end

    // Later (higher) indices overwrite, so the highest claimable wins
    always_comb begin
        claimable = pend & cfg_enable & ~serv;
        sel       = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (claimable[i]) begin
                sel   = ID_W'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        set_vec   = '0;
        claim_vec = '0;
        done_vec  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            st_d[i] = st_q[i];
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            set_vec[i]   = cfg_edge[i] ? rise[i]
                                       : (lvl[i] & ~serv[i] & ~pend[i]);
            claim_vec[i] = claim_req & found & (sel == ID_W'(i));
            done_vec[i]  = complete_valid & (complete_id == ID_W'(i))
                           & serv[i];
            st_d[i]      = src_next(st_q[i], set_vec[i],
                                    claim_vec[i], done_vec[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                st_q[i] <= IDLE;
            end
            req_q       <= '0;
            claim_valid <= 1'b0;
            claim_none  <= 1'b0;
            claim_id    <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                st_q[i] <= st_d[i];
            end
            req_q       <= pend & cfg_enable & ~serv;
            claim_valid <= claim_req;
            claim_none  <= claim_req & ~found;
            if (claim_req) begin
                claim_id <= found ? sel : '0;
            end
        end
    end

    assign peripheral_ints = req_q;
    assign in_service      = serv;

`ifdef IRQ_GATEWAY_DROP_CNT_EN
    logic [7:0] cnt_q [NUM_SRC];
    logic [7:0] drop_q;

    // A claim clears the count even if an edge lands in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= '0;
            end
            drop_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (claim_vec[i]) begin
                    cnt_q[i] <= '0;
                end else if (rise[i] && pend[i] && cnt_q[i] != 8'hFF) begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
            drop_q <= cnt_q[cnt_sel];
        end
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_irq_gateway.sv
// Directed testbench for irq_gateway: vector table plus corner sequences.
// Drop counter checks are compiled in with IRQ_GATEWAY_DROP_CNT_EN.
module tb_irq_gateway;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] irq_src = '0;
    logic [15:0] cfg_edge = 16'hFFFF;
    logic [15:0] cfg_enable = 16'hFFFF;
    logic        claim_req = 1'b0;
    logic        claim_valid;
    logic        claim_none;
    logic [3:0]  claim_id;
    logic        complete_valid = 1'b0;
    logic [3:0]  complete_id = '0;
    logic [15:0] peripheral_ints;
    logic [15:0] in_service;
`ifdef IRQ_GATEWAY_DROP_CNT_EN
    logic [3:0]  cnt_sel = '0;
    logic [7:0]  drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    irq_gateway dut (
        .clk             (clk),
        .rst             (rst),
        .irq_src         (irq_src),
        .cfg_edge        (cfg_edge),
        .cfg_enable      (cfg_enable),
        .claim_req       (claim_req),
        .claim_valid     (claim_valid),
        .claim_none      (claim_none),
        .claim_id        (claim_id),
        .complete_valid  (complete_valid),
        .complete_id     (complete_id),
`ifdef IRQ_GATEWAY_DROP_CNT_EN
        .cnt_sel         (cnt_sel),
        .drop_cnt        (drop_cnt),
`endif
        .peripheral_ints (peripheral_ints),
        .in_service      (in_service)
    );

    typedef struct {
        logic        rst;
        logic [15:0] src;
        logic        clm;
        logic        cmp;
        logic [3:0]  cid;
        logic [15:0] pi;
        logic [15:0] isv;
        logic        cv;
        logic        cn;
        logic [3:0]  id;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(
        input logic r, input logic [15:0] src, input logic clm,
        input logic cmp, input logic [3:0] cid, input logic [15:0] pi,
        input logic [15:0] isv, input logic cv, input logic cn,
        input logic [3:0] id
    );
        vec_t v;
        v.rst = r;   v.src = src; v.clm = clm; v.cmp = cmp; v.cid = cid;
        v.pi  = pi;  v.isv = isv; v.cv  = cv;  v.cn  = cn;  v.id  = id;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse(input int idx);
        irq_src[idx] = 1'b1;
        tick();
        irq_src[idx] = 1'b0;
    endtask

    task automatic claim();
        claim_req = 1'b1;
        tick();
        claim_req = 1'b0;
    endtask

    task automatic complete(input logic [3:0] id);
        complete_valid = 1'b1;
        complete_id    = id;
        tick();
        complete_valid = 1'b0;
    endtask

    function automatic logic [5:0] cresp();
        return {claim_valid, claim_none, claim_id};
    endfunction

    initial begin
        tbl[0]  = mk(1, 16'h0000, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 0);
        tbl[1]  = mk(0, 16'h0020, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 0);
        tbl[2]  = mk(0, 16'h0000, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 0);
        tbl[3]  = mk(0, 16'h0000, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 0);
        tbl[4]  = mk(0, 16'h0000, 0, 0, 0,  16'h0020, 16'h0000, 0, 0, 0);
        tbl[5]  = mk(0, 16'h0000, 1, 0, 0,  16'h0020, 16'h0020, 1, 0, 5);
        tbl[6]  = mk(0, 16'h0000, 0, 0, 0,  16'h0000, 16'h0020, 0, 0, 0);
        tbl[7]  = mk(0, 16'h0000, 0, 1, 5,  16'h0000, 16'h0000, 0, 0, 0);
        tbl[8]  = mk(0, 16'h4208, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 0);
        tbl[9]  = mk(0, 16'h0000, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 0);
        tbl[10] = mk(0, 16'h0000, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 0);
        tbl[11] = mk(0, 16'h0000, 0, 0, 0,  16'h4208, 16'h0000, 0, 0, 0);
        tbl[12] = mk(0, 16'h0000, 1, 0, 0,  16'h4208, 16'h4000, 1, 0, 14);
        tbl[13] = mk(0, 16'h0000, 1, 0, 0,  16'h0208, 16'h4200, 1, 0, 9);
        tbl[14] = mk(0, 16'h0000, 1, 0, 0,  16'h0008, 16'h4208, 1, 0, 3);
        tbl[15] = mk(0, 16'h0000, 1, 0, 0,  16'h0000, 16'h4208, 1, 1, 0);
        tbl[16] = mk(0, 16'h0000, 0, 1, 14, 16'h0000, 16'h0208, 0, 0, 0);
        tbl[17] = mk(0, 16'h0000, 0, 1, 9,  16'h0000, 16'h0008, 0, 0, 0);
        tbl[18] = mk(0, 16'h0000, 0, 1, 3,  16'h0000, 16'h0000, 0, 0, 0);
        tbl[19] = mk(0, 16'h0000, 0, 1, 10, 16'h0000, 16'h0000, 0, 0, 0);

        for (int r = 0; r < 20; r++) begin
            rst            = tbl[r].rst;
            irq_src        = tbl[r].src;
            claim_req      = tbl[r].clm;
            complete_valid = tbl[r].cmp;
            complete_id    = tbl[r].cid;
            tick();
            check($sformatf("row%0d", r),
                  {26'd0, peripheral_ints, in_service, claim_valid,
                   claim_none, claim_valid ? claim_id : 4'h0},
                  {26'd0, tbl[r].pi, tbl[r].isv, tbl[r].cv, tbl[r].cn,
                   tbl[r].cv ? tbl[r].id : 4'h0});
        end
        claim_req      = 1'b0;
        complete_valid = 1'b0;

        // Level source re-arms after completion while still asserted
        cfg_edge   = 16'hFFFB;
        irq_src[2] = 1'b1;
        ticks(4);
        check("lvl_req", 64'(peripheral_ints), 64'h0004);
        claim();
        check("lvl_claim", 64'(cresp()), {58'd0, 2'b10, 4'd2});
        tick();
        check("lvl_serv", {peripheral_ints, in_service}, 64'h0000_0004);
        ticks(3);
        check("lvl_hold", {peripheral_ints, in_service}, 64'h0000_0004);
        complete(4'd2);
        check("lvl_done", {peripheral_ints, in_service}, 64'h0000_0000);
        tick();
        check("lvl_rearm_lat", 64'(peripheral_ints), 64'h0000);
        tick();
        check("lvl_rearm", 64'(peripheral_ints), 64'h0004);
        irq_src[2] = 1'b0;
        ticks(3);
        claim();
        complete(4'd2);
        ticks(3);
        check("lvl_clean", {peripheral_ints, in_service}, 64'h0000_0000);
        cfg_edge = 16'hFFFF;

        // Edge arriving while in service is held as SERV_PEND
        pulse(7);
        ticks(3);
        check("svc_req", 64'(peripheral_ints), 64'h0080);
        claim();
        check("svc_claim", 64'(cresp()), {58'd0, 2'b10, 4'd7});
        pulse(7);
        ticks(3);
        check("svc_edge", {peripheral_ints, in_service}, 64'h0000_0080);
        complete(4'd10);
        check("ign_cmp", 64'(in_service), 64'h0080);
        complete(4'd7);
        tick();
        check("svc_repend", {peripheral_ints, in_service}, 64'h0080_0000);
        complete(4'd7);
        tick();
        check("ign_pend_cmp", {peripheral_ints, in_service}, 64'h0080_0000);
        claim();
        check("svc_claim2", 64'(cresp()), {58'd0, 2'b10, 4'd7});
        complete(4'd7);
        tick();
        check("svc_clean", {peripheral_ints, in_service}, 64'h0000_0000);

        // Disabled source keeps pending but is neither requested nor claimable
        cfg_enable = 16'hFFEF;
        pulse(4);
        ticks(4);
        check("mask_req", 64'(peripheral_ints), 64'h0000);
        claim();
        check("mask_claim", 64'(cresp()), {58'd0, 2'b11, 4'd0});
        cfg_enable = 16'hFFFF;
        tick();
        check("unmask", 64'(peripheral_ints), 64'h0010);
        claim();
        check("unmask_claim", 64'(cresp()), {58'd0, 2'b10, 4'd4});
        complete(4'd4);

        // Reset coinciding with a claim aborts it
        pulse(12);
        ticks(4);
        check("rst_pre", 64'(peripheral_ints), 64'h1000);
        claim_req = 1'b1;
        rst       = 1'b1;
        tick();
        claim_req = 1'b0;
        rst       = 1'b0;
        check("rst_claim", {26'd0, cresp(), peripheral_ints, in_service},
              64'd0);
        ticks(4);
        check("rst_state", {peripheral_ints, in_service}, 64'h0000_0000);

`ifdef IRQ_GATEWAY_DROP_CNT_EN
        cnt_sel = 4'd1;
        pulse(1);
        ticks(3);
        for (int k = 0; k < 3; k++) begin
            pulse(1);
            tick();
        end
        ticks(4);
        check("drop_cnt", 64'(drop_cnt), 64'd3);
        claim();
        check("drop_claim", 64'(cresp()), {58'd0, 2'b10, 4'd1});
        ticks(2);
        check("drop_clr", 64'(drop_cnt), 64'd0);
        complete(4'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
